// File: rtl/mips32_soc_pkg.sv
// Shared word geometry, default IMEM depth and loader FSM encoding for the MIPS32 SoC boot path.
// The CHECK state exists only when IMEM_LOADER_CSUM_EN is defined.
package mips32_soc_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int IMEM_ADDR_W    = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef IMEM_LOADER_CSUM_EN
    CHECK = 2'd2,
`endif
    DONE  = 2'd3
  } ldr_state_e;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer; word_vld pulses one cycle after the final byte of each word.
// Accepts a byte on every byte_vld with no stall; a partial word survives idle gaps until clr.
module byte_packer
  import mips32_soc_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_dat,
  output logic              last_byte,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_dat
);

  localparam int               CNT_W    = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0]         byte_cnt;
  logic [WORD_W-BYTE_W-1:0] shift_q;

  assign last_byte = byte_vld && (byte_cnt == CNT_LAST);

  // word_dat is held separately so the next word's bytes can shift in during the write cycle
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      shift_q  <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
      shift_q  <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= last_byte;
      if (byte_vld) begin
        byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
        shift_q  <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_dat};
        if (last_byte) begin
          word_dat <= {shift_q, byte_dat};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into IMEM writes (1 cycle after each 4th byte) while holding the core in reset.
// in_ready drops after the last needed byte; IMEM_LOADER_CSUM_EN adds a trailing XOR checksum word and csum_err.
module imem_loader
  import mips32_soc_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
`ifdef IMEM_LOADER_CSUM_EN
  ,
  output logic              csum_err
`endif
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  ldr_state_e        state, state_nxt;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   rcv_cnt;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   wr_cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              start_acc;
  logic              in_fire;
  logic              last_byte;
  logic              word_vld;
  logic              last_wr;
  logic [WORD_W-1:0] word_dat;

  assign start_acc  = start && ((state == IDLE) || (state == DONE));
  assign in_fire    = in_valid && in_ready;
  assign wr_cnt_nxt = wr_cnt + CNT_ONE;
  assign last_wr    = (wr_cnt_nxt == len_q);
  assign mem_addr   = addr_q;
  assign mem_wdata  = word_dat;

  byte_packer u_packer (
    .CLK       (CLK),
    .reset     (reset),
    .clr       (start_acc),
    .byte_vld  (in_fire),
    .byte_dat  (in_data),
    .last_byte (last_byte),
    .word_vld  (word_vld),
    .word_dat  (word_dat)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (word_vld && last_wr) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CHECK: begin
        if (word_vld) begin
          state_nxt = DONE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CSUM_EN
  logic [WORD_W-1:0] csum_acc;
  logic              csum_got;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      csum_acc <= '0;
      csum_got <= 1'b0;
      csum_err <= 1'b0;
    end else if (start_acc) begin
      csum_acc <= '0;
      csum_got <= 1'b0;
      csum_err <= 1'b0;
    end else begin
      if (mem_we) begin
        csum_acc <= csum_acc ^ word_dat;
      end
      if ((state == CHECK) && last_byte) begin
        csum_got <= 1'b1;
      end
      if ((state == CHECK) && word_vld) begin
        csum_err <= (word_dat != csum_acc);
      end
    end
  end
`endif

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    cpu_hold = 1'b1;
    unique case (state)
      LOAD: begin
        busy     = 1'b1;
        in_ready = (rcv_cnt < len_q);
        mem_we   = word_vld;
      end
`ifdef IMEM_LOADER_CSUM_EN
      CHECK: begin
        busy     = 1'b1;
        in_ready = !csum_got;
      end
`endif
      DONE: begin
        done = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
        cpu_hold = csum_err;
`else
        cpu_hold = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // Address saturates on the final write so a full-depth load never lands back on word 0
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      len_q   <= '0;
      rcv_cnt <= '0;
      wr_cnt  <= '0;
      addr_q  <= '0;
    end else if (start_acc) begin
      len_q   <= len;
      rcv_cnt <= '0;
      wr_cnt  <= '0;
      addr_q  <= '0;
    end else begin
      if ((state == LOAD) && last_byte) begin
        rcv_cnt <= rcv_cnt + CNT_ONE;
      end
      if (mem_we) begin
        wr_cnt <= wr_cnt_nxt;
        if (!last_wr) begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
    end
  end

  a_we_busy : assert property (@(posedge CLK) disable iff (!reset) mem_we |-> busy);
  a_fire_busy : assert property (@(posedge CLK) disable iff (!reset) in_fire |-> busy);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, multi-cycle corner sequences and random loads vs a byte-stream model.
module tb_imem_loader;

  localparam int AW   = 4;
  localparam int NMAX = 1 << AW;

  typedef struct {
    int          l;
    int          mode;
    logic [63:0] b;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
`ifdef IMEM_LOADER_CSUM_EN
  logic          csum_err;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          hs_cyc_q[$];
  logic [7:0]  buf_q[$];

  imem_loader #(.ADDR_W(AW)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done)
`ifdef IMEM_LOADER_CSUM_EN
    ,
    .csum_err  (csum_err)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  // Handshakes are tagged with the edge that takes them; writes with the edge that opened their cycle
  always @(negedge CLK) begin
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (in_valid && in_ready) hs_cyc_q.push_back(cyc + 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    hs_cyc_q.delete();
  endtask

  task automatic pulse_start(input int l);
    len   = (AW+1)'(l);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic send_bytes(input int from, input int to, input int mode);
    int idx = from;
    int g   = 0;
    bit hs;
    while (idx < to && g < 4000) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ((g % 2) == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = buf_q[idx];
      @(negedge CLK);
      hs = in_valid && in_ready;
      @(posedge CLK); #1;
      if (hs) idx++;
      g++;
    end
    in_valid = 1'b0;
    chk("send_deadline", idx, to);
  endtask

  // Junk stays offered after the real stream so any extra acceptance shows up in the byte count
  task automatic finish_load(input string tag);
    int g = 0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    while (!done && g < 40) begin
      @(posedge CLK); #1;
      g++;
    end
    in_valid = 1'b0;
    chk({tag, " done_deadline"}, 32'(done), 1);
  endtask

  task automatic run_load(input string tag, input int l, input int mode);
    clear_mon();
    pulse_start(l);
    send_bytes(0, buf_q.size(), mode);
    finish_load(tag);
  endtask

  task automatic add_tail(input int l, input logic [31:0] flip);
`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0] x = '0;
    if (l > 0) begin
      for (int i = 0; i < l; i++) x ^= {buf_q[4*i], buf_q[4*i+1], buf_q[4*i+2], buf_q[4*i+3]};
      x ^= flip;
      for (int k = 0; k < 4; k++) buf_q.push_back(x[31-8*k -: 8]);
    end
`else
    if (flip != 0 || l < 0) $display("note: checksum tail not built");
`endif
  endtask

  task automatic fill_rand(input int l);
    buf_q.delete();
    for (int k = 0; k < 4*l; k++) buf_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Model: word i is bytes 4i..4i+3 big-endian at address i, written on the cycle after byte 4i+3
  task automatic verify(input string tag, input int l, input bit exp_hold);
    int nw;
    chk({tag, " nwrites"}, wr_addr_q.size(), l);
    chk({tag, " nbytes"}, hs_cyc_q.size(), buf_q.size());
    nw = (wr_addr_q.size() < l) ? wr_addr_q.size() : l;
    for (int i = 0; i < nw; i++) begin
      chk({tag, " addr"}, wr_addr_q[i], i);
      chk({tag, " data"}, wr_data_q[i], {buf_q[4*i], buf_q[4*i+1], buf_q[4*i+2], buf_q[4*i+3]});
      if (4*i+3 < hs_cyc_q.size()) chk({tag, " latency"}, wr_cyc_q[i], hs_cyc_q[4*i+3]);
    end
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " cpu_hold"}, 32'(cpu_hold), 32'(exp_hold));
    chk({tag, " in_ready"}, 32'(in_ready), 0);
`ifdef IMEM_LOADER_CSUM_EN
    chk({tag, " csum_err"}, 32'(csum_err), 32'(exp_hold));
`endif
    repeat (3) @(posedge CLK);
    #1;
    chk({tag, " no_extra_we"}, wr_addr_q.size(), l);
  endtask

  initial begin
    vec_t vt[5];
    int   l;
    vt[0] = '{2, 0, 64'h0000AABB_0000A0B0, 2, 32'h0000AABB, 32'h0000A0B0};
    vt[1] = '{2, 1, 64'h0000AABB_0000A0B0, 2, 32'h0000AABB, 32'h0000A0B0};
    vt[2] = '{1, 0, 64'hDEADBEEF_00000000, 1, 32'hDEADBEEF, 32'h0};
    vt[3] = '{0, 0, 64'h0,                 0, 32'h0,        32'h0};
    vt[4] = '{2, 2, 64'h12345678_9ABCDEF0, 2, 32'h12345678, 32'h9ABCDEF0};

    // Reset values, then an idle core stays held with no writes
    repeat (2) @(posedge CLK);
    #1;
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst cpu_hold", 32'(cpu_hold), 1);
    reset = 1'b1;
    clear_mon();
    repeat (10) @(posedge CLK);
    #1;
    chk("idle cpu_hold", 32'(cpu_hold), 1);
    chk("idle done", 32'(done), 0);
    chk("idle writes", wr_addr_q.size(), 0);

    // len=0 from IDLE reaches DONE on the very next cycle
    pulse_start(0);
    chk("len0 done_next", 32'(done), 1);
    chk("len0 cpu_hold", 32'(cpu_hold), 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("len0 writes", wr_addr_q.size(), 0);

    for (int v = 0; v < 5; v++) begin
      buf_q.delete();
      for (int k = 0; k < 4*vt[v].l; k++) buf_q.push_back(vt[v].b[63-8*k -: 8]);
      add_tail(vt[v].l, 32'h0);
      run_load($sformatf("vec%0d", v), vt[v].l, vt[v].mode);
      chk($sformatf("vec%0d table_nwr", v), wr_data_q.size(), vt[v].nwr);
      if (vt[v].nwr > 0 && wr_data_q.size() > 0) chk($sformatf("vec%0d table_w0", v), wr_data_q[0], vt[v].w0);
      if (vt[v].nwr > 1 && wr_data_q.size() > 1) chk($sformatf("vec%0d table_w1", v), wr_data_q[1], vt[v].w1);
      verify($sformatf("vec%0d", v), vt[v].l, 1'b0);
    end

    // A start mid-load is ignored: length and partial word survive
    buf_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    add_tail(2, 32'h0);
    clear_mon();
    pulse_start(2);
    send_bytes(0, 3, 0);
    pulse_start(1);
    send_bytes(3, buf_q.size(), 1);
    finish_load("restart_ignored");
    verify("restart_ignored", 2, 1'b0);

    // Reset after 6 bytes of a 2-word load: one write only, then a clean reload from address 0
    buf_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    clear_mon();
    pulse_start(2);
    send_bytes(0, 6, 0);
    reset = 1'b0;
    @(negedge CLK);
    chk("abort writes", wr_addr_q.size(), 1);
    if (wr_data_q.size() > 0) chk("abort w0", wr_data_q[0], 32'h11223344);
    chk("abort in_ready", 32'(in_ready), 0);
    chk("abort mem_we", 32'(mem_we), 0);
    chk("abort mem_addr", 32'(mem_addr), 0);
    chk("abort mem_wdata", mem_wdata, 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort cpu_hold", 32'(cpu_hold), 1);
    @(posedge CLK); #1;
    reset = 1'b1;
    @(posedge CLK); #1;
    buf_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hD2, 8'hD3};
    add_tail(2, 32'h0);
    run_load("reload", 2, 0);
    verify("reload", 2, 1'b0);

    // Full-depth load: last write at the top address, nothing wraps to 0
    fill_rand(NMAX);
    add_tail(NMAX, 32'h0);
    run_load("full_depth", NMAX, 2);
    verify("full_depth", NMAX, 1'b0);

    for (int r = 0; r < 6; r++) begin
      l = $urandom_range(1, NMAX);
      fill_rand(l);
      add_tail(l, 32'h0);
      run_load($sformatf("rand%0d", r), l, $urandom_range(0, 2));
      verify($sformatf("rand%0d", r), l, 1'b0);
    end

`ifdef IMEM_LOADER_CSUM_EN
    buf_q = '{8'h00, 8'h00, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'hA0, 8'hB0};
    add_tail(2, 32'h0000_0007);
    chk("csum_bad byte3", 32'(buf_q[11]), 32'h0C);
    run_load("csum_bad", 2, 0);
    verify("csum_bad", 2, 1'b1);
    pulse_start(0);
    chk("csum clear_on_start", 32'(csum_err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
